mem_ctrl: RTL

Byte-wide RAM port controller and arbiter; the responder side of the instruction-fetch byte-request protocol.
- Grants fetch byte reads from the IF unit.
- Serves 1/2/4-byte loads and stores from the load/store buffer (LSB) as sequential byte accesses.
- Holds IO-region writes while the IO buffer is full.
- Sits between IF/LSB and the single-port RAM; RAM read data returns one cycle after the address is driven.

---
 rtl/mem_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// Byte-wide RAM port controller: arbitrates IF byte fetches against LSB loads/stores,
// serialising multi-byte LSB accesses into sequential byte cycles on a single-port RAM.
module mem_ctrl #(
  parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [7:0]  ram_din,
  output logic [7:0]  ram_dout,
  output logic [31:0] ram_a,
  output logic        ram_wr,
  input  logic        io_buffer_full,
  input  logic        clear,
  input  logic        if_access_control,
  input  logic [31:0] if_addr,
  output logic        if_access_valid,
  output logic [7:0]  if_mem_din,
  input  logic        lsb_req,
  input  logic        lsb_wr,
  input  logic [31:0] lsb_addr,
  input  logic [1:0]  lsb_len,
  input  logic [31:0] lsb_wdata,
  output logic        lsb_busy,
  output logic        lsb_done,
  output logic [31:0] lsb_rdata
);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD      = 2'd1;
  localparam logic [1:0] S_RD_WAIT = 2'd2;
  localparam logic [1:0] S_WR      = 2'd3;

  logic [1:0]  r_state, r_cnt, r_last;
  logic [31:0] r_addr, r_wdata, r_buf, r_rdata, r_prev_a;
  logic        r_done;

  logic [31:0] w_byte_a, w_a, w_rdata_fin;
  logic [7:0]  w_dout;
  logic        w_wr, w_grant, w_accept, w_io_stall, w_last;

  assign w_byte_a   = r_addr + {30'd0, r_cnt};
  assign w_io_stall = io_buffer_full && (w_byte_a >= IO_BASE);
  assign w_last     = (r_cnt == r_last);
  assign w_accept   = (r_state == S_IDLE) && lsb_req && !clear;
  assign w_grant    = (r_state == S_IDLE) && !lsb_req && !clear && if_access_control;

  always_comb begin
    w_a    = '0;
    w_wr   = 1'b0;
    w_dout = '0;
    case (r_state)
      S_IDLE: if (w_grant) w_a = if_addr;
      S_RD, S_RD_WAIT: w_a = w_byte_a;
      S_WR: begin
        w_a    = w_byte_a;
        w_dout = r_wdata[{r_cnt, 3'b000} +: 8];
        w_wr   = !w_io_stall;
      end
      default: ;
    endcase
  end

  // Final load word: buffered bytes plus the last byte arriving from RAM this cycle.
  always_comb begin
    w_rdata_fin = r_buf;
    w_rdata_fin[{r_last, 3'b000} +: 8] = ram_din;
  end

  // While frozen, keep the last driven address so RAM read data stays aligned with cnt.
  always_comb begin
    ram_a           = w_a;
    ram_wr          = w_wr;
    ram_dout        = w_dout;
    if_access_valid = w_grant;
    if (rst_in) begin
      ram_a           = '0;
      ram_wr          = 1'b0;
      ram_dout        = '0;
      if_access_valid = 1'b0;
    end else if (!rdy_in) begin
      ram_a           = r_prev_a;
      ram_wr          = 1'b0;
      if_access_valid = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_rdata  <= '0;
      r_prev_a <= '0;
    end else if (rdy_in) begin
      r_done   <= 1'b0;
      r_prev_a <= w_a;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_cnt   <= '0;
          r_state <= lsb_wr ? S_WR : S_RD;
        end
        S_RD: begin
          if (clear)       r_state <= S_IDLE;
          else if (w_last) r_state <= S_RD_WAIT;
          else             r_cnt   <= r_cnt + 2'd1;
        end
        S_RD_WAIT: begin
          r_state <= S_IDLE;
          if (!clear) begin
            r_done  <= 1'b1;
            r_rdata <= w_rdata_fin;
          end
        end
        S_WR: if (!w_io_stall) begin
          if (w_last) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Byte k of a load is on ram_din while cnt == k+1, one cycle after its address.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      if (w_accept) begin
        r_addr  <= lsb_addr;
        r_wdata <= lsb_wdata;
        r_last  <= (lsb_len == 2'd0) ? 2'd0 : (lsb_len == 2'd1) ? 2'd1 : 2'd3;
        r_buf   <= '0;
      end else if ((r_state == S_RD) && (r_cnt != 2'd0)) begin
        r_buf[{r_cnt - 2'd1, 3'b000} +: 8] <= ram_din;
      end
    end
  end

  assign if_mem_din = ram_din;
  assign lsb_busy   = (r_state != S_IDLE);
  assign lsb_done   = r_done;
  assign lsb_rdata  = r_rdata;

endmodule
